// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with optional write-to-read bypass
// and a pending-write scoreboard for RAW hazard detection in decode.
module regfile_mp #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int NRD     = 2,
  parameter int NWR     = 1,
  parameter int BYPASS  = 1,
  parameter int R0_ZERO = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr
);
  logic [XLEN-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic [AW-1:0] w_wa [NWR];
  logic [XLEN-1:0] w_wd [NWR];
  logic [NWR-1:0] w_wok;
  logic w_aok;
  for (genvar i = 0; i < NWR; i++) begin : g_wr
    assign w_wa[i] = wa[i*AW +: AW];
    assign w_wd[i] = wd[i*XLEN +: XLEN];
    assign w_wok[i] = we[i] && int'(w_wa[i]) < NREGS && !(R0_ZERO != 0 && w_wa[i] == '0);
  end
  assign w_aok = alloc_en && int'(alloc_addr) < NREGS && !(R0_ZERO != 0 && alloc_addr == '0);
  // Completing writes clear busy first so a same-cycle alloc re-sets it.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < NWR; i++)
      if (w_wok[i]) w_busy_nxt[w_wa[i]] = 1'b0;
    if (w_aok) w_busy_nxt[alloc_addr] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) r_regs[r] <= '0;
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NWR; i++)
        if (w_wok[i]) r_regs[w_wa[i]] <= w_wd[i];
      r_busy <= w_busy_nxt;
    end
  end
  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic w_in, w_z, w_byp;
    logic [XLEN-1:0] w_bd;
    assign w_ra = rd_addr[j*AW +: AW];
    assign w_in = int'(w_ra) < NREGS;
    assign w_z = R0_ZERO != 0 && w_ra == '0;
    // Later ports overwrite earlier matches, so the highest writer is forwarded.
    always_comb begin
      w_byp = 1'b0;
      w_bd = '0;
      for (int i = 0; i < NWR; i++)
        if (BYPASS != 0 && rst_n && w_wok[i] && w_wa[i] == w_ra) begin
          w_byp = 1'b1;
          w_bd = w_wd[i];
        end
    end
    assign rd_data[j*XLEN +: XLEN] = (!w_in || w_z) ? '0 : w_byp ? w_bd : r_regs[w_ra];
    assign rd_busy[j] = w_in && !w_z && !w_byp && r_busy[w_ra];
  end
endmodule
